// File: rtl/gf2_31_prng_core.sv
// GF(2^31) PRNG core: 31-bit state advanced by f(s) = ((x^4+1)*s + 1) mod (x^31+x^13+x^8+x^3+1),
// with seed loading, burst/continuous run control, valid/ready output and sticky fixed-point flag.

module gf2_poly_affine_mod_31 (
  input  logic [30:0] in_poly,
  output logic [30:0] out_poly
);
  // x^31 == x^13 + x^8 + x^3 + 1 under the modulus
  localparam logic [30:0] RED = 31'h0000_2109;

  logic [34:0] prod;

  always_comb begin
    prod     = {4'b0000, in_poly} ^ {in_poly, 4'b0000};
    out_poly = prod[30:0];
    // Overflow terms x^31..x^34 fold to at most x^16, so one pass suffices
    for (int unsigned i = 0; i < 4; i++) begin
      if (prod[31 + i]) out_poly = out_poly ^ (RED << i);
    end
    out_poly = out_poly ^ 31'd1;
  end
endmodule

module gf2_31_prng_core #(
  parameter logic [30:0] RESET_SEED = 31'd1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [30:0]      seed,
  input  logic             start,
  input  logic [15:0]      burst_len,
  input  logic             stop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [30:0]      out_data,
  output logic             busy,
  output logic             stuck,
  output logic [CNT_W-1:0] word_cnt
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [30:0]       s_q, s_d;
  logic [15:0]       remaining_q, remaining_d;
  logic              stuck_q, stuck_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;

  logic [30:0]       f_in, f_out;
  logic              xfer;

  // In IDLE a seed_load redirects the next-state function onto the new seed
  assign f_in = (state_q == IDLE && seed_load) ? seed : s_q;

  gf2_poly_affine_mod_31 u_affine (
    .in_poly  (f_in),
    .out_poly (f_out)
  );

  assign busy      = (state_q == RUN);
  assign out_valid = busy;
  assign out_data  = s_q;
  assign stuck     = stuck_q;
  assign word_cnt  = word_cnt_q;
  assign xfer      = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    remaining_d = remaining_q;
    stuck_d     = stuck_q;
    word_cnt_d  = word_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (seed_load && start) begin
          s_d         = f_out;
          stuck_d     = (f_out == seed);
          word_cnt_d  = '0;
          remaining_d = burst_len;
          state_d     = RUN;
        end else if (seed_load) begin
          s_d        = seed;
          stuck_d    = 1'b0;
          word_cnt_d = '0;
        end else if (start) begin
          s_d         = f_out;
          stuck_d     = stuck_q | (f_out == s_q);
          remaining_d = burst_len;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          word_cnt_d = word_cnt_q + CNT_W'(1);
          if (remaining_q == 16'd1) begin
            state_d     = IDLE;
            remaining_d = '0;
          end else begin
            s_d     = f_out;
            stuck_d = stuck_q | (f_out == s_q);
            if (remaining_q != '0) remaining_d = remaining_q - 16'd1;
          end
        end
        // Stop only ends the run; a concurrent transfer above still advances S
        if (stop) begin
          state_d     = IDLE;
          remaining_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= RESET_SEED;
      remaining_q <= '0;
      stuck_q     <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      remaining_q <= remaining_d;
      stuck_q     <= stuck_d;
      word_cnt_q  <= word_cnt_d;
    end
  end
endmodule

// File: tb/tb_gf2_31_prng_core.sv
// Self-checking bench for gf2_31_prng_core against a polynomial-arithmetic reference model.

module tb_gf2_31_prng_core;
  logic        clk = 1'b0;
  logic        rst, seed_load, start, stop, out_ready;
  logic [30:0] seed;
  logic [15:0] burst_len;
  logic        out_valid, busy, stuck;
  logic [30:0] out_data;
  logic [31:0] word_cnt;

  int checks = 0;
  int errors = 0;

  logic [30:0] m;
  logic [31:0] exp_cnt;

  localparam logic [31:0] POLY = 32'h8000_2109;

  gf2_31_prng_core #(.RESET_SEED(31'd1), .CNT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load),
    .seed      (seed),
    .start     (start),
    .burst_len (burst_len),
    .stop      (stop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .stuck     (stuck),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [30:0] gf_mulmod(input logic [30:0] a, input logic [30:0] b);
    logic [61:0] acc;
    acc = '0;
    for (int i = 0; i < 31; i++)
      if (b[i]) acc = acc ^ ({31'b0, a} << i);
    for (int i = 61; i >= 31; i--)
      if (acc[i]) acc = acc ^ ({30'b0, POLY} << (i - 31));
    return acc[30:0];
  endfunction

  function automatic logic [30:0] gf_f(input logic [30:0] s);
    return gf_mulmod(s, 31'h11) ^ 31'd1;
  endfunction

  function automatic logic [30:0] gf_div_x(input logic [30:0] s);
    logic [31:0] t;
    t = {1'b0, s};
    if (t[0]) t = t ^ POLY;
    return t[31:1];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    seed_load = 0; start = 0; stop = 0; out_ready = 0; seed = '0; burst_len = '0;
  endtask

  task automatic do_seed(input logic [30:0] v);
    seed = v; seed_load = 1; tick(); seed_load = 0;
    m = v; exp_cnt = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (stuck !== 1'b0) begin errors++; $display("FAIL reset_stuck got %0b exp 0", stuck); end
    checks++; if (word_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", word_cnt); end
    checks++; if (out_data !== 31'd1) begin errors++; $display("FAIL reset_data got %0d exp 1", out_data); end
    rst = 0;
  endtask

  task automatic test_burst();
    logic [30:0] golden [3];
    golden[0] = 31'd16; golden[1] = 31'd273; golden[2] = 31'd4096;
    out_ready = 1; burst_len = 16'd3; start = 1; tick(); start = 0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== golden[k]) begin
        errors++; $display("FAIL burst_word%0d got %0d/v%0b exp %0d/v1", k, out_data, out_valid, golden[k]); end
      tick();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL burst_busy got %0b exp 0", busy); end
    checks++; if (word_cnt !== 32'd3) begin errors++; $display("FAIL burst_cnt got %0d exp 3", word_cnt); end
    tick();
    checks++; if (out_data !== 31'd4096) begin errors++; $display("FAIL burst_hold got %0d exp 4096", out_data); end
    out_ready = 0;
  endtask

  task automatic test_seed_start();
    seed = 31'd478163327; seed_load = 1; start = 1; burst_len = 16'd1; out_ready = 1;
    tick(); seed_load = 0; start = 0;
    checks++; if (out_valid !== 1'b1 || out_data !== 31'd1417889173) begin
      errors++; $display("FAIL seedstart_word got %0d/v%0b exp 1417889173/v1", out_data, out_valid); end
    checks++; if (word_cnt !== 32'd0) begin errors++; $display("FAIL seedstart_cnt0 got %0d exp 0", word_cnt); end
    tick();
    checks++; if (busy !== 1'b0 || word_cnt !== 32'd1) begin
      errors++; $display("FAIL seedstart_end got busy%0b cnt%0d exp busy0 cnt1", busy, word_cnt); end
    out_ready = 0;
  endtask

  task automatic test_backpressure();
    do_seed(31'd1);
    burst_len = 16'd2; out_ready = 0; start = 1; tick(); start = 0;
    for (int k = 0; k < 5; k++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 31'd16) begin
        errors++; $display("FAIL bp_hold%0d got %0d/v%0b exp 16/v1", k, out_data, out_valid); end
      tick();
    end
    out_ready = 1;
    checks++; if (out_data !== 31'd16) begin errors++; $display("FAIL bp_first got %0d exp 16", out_data); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 31'd273) begin
      errors++; $display("FAIL bp_second got %0d/v%0b exp 273/v1", out_data, out_valid); end
    tick();
    checks++; if (busy !== 1'b0 || word_cnt !== 32'd2) begin
      errors++; $display("FAIL bp_end got busy%0b cnt%0d exp busy0 cnt2", busy, word_cnt); end
    out_ready = 0;
  endtask

  task automatic test_continuous();
    do_seed(31'd0);
    burst_len = 16'd0; start = 1; tick(); start = 0;
    m = gf_f(m);
    checks++; if (out_data !== 31'd1) begin errors++; $display("FAIL cont_first got %0d exp 1", out_data); end
    for (int k = 0; k < 60; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      seed_load = 1'($urandom_range(0, 1));
      start     = 1'($urandom_range(0, 1));
      seed      = 31'($urandom);
      burst_len = 16'($urandom_range(1, 3));
      checks++; if (out_valid !== 1'b1 || out_data !== m || word_cnt !== exp_cnt) begin
        errors++; $display("FAIL cont_word%0d got %0d/v%0b/c%0d exp %0d/v1/c%0d", k, out_data, out_valid, word_cnt, m, exp_cnt); end
      tick();
      if (out_ready) begin exp_cnt++; m = gf_f(m); end
    end
    seed_load = 0; start = 0;
    out_ready = 1; stop = 1;
    checks++; if (out_data !== m) begin errors++; $display("FAIL cont_stopword got %0d exp %0d", out_data, m); end
    tick(); stop = 0; out_ready = 0;
    exp_cnt++; m = gf_f(m);
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL cont_stop got busy%0b v%0b exp 0/0", busy, out_valid); end
    checks++; if (word_cnt !== exp_cnt || out_data !== m) begin
      errors++; $display("FAIL cont_after got c%0d d%0d exp c%0d d%0d", word_cnt, out_data, exp_cnt, m); end
  endtask

  task automatic test_random_burst();
    int got, cyc, bl;
    for (int r = 0; r < 6; r++) begin
      do_seed(31'($urandom));
      bl = $urandom_range(1, 6);
      burst_len = 16'(bl); start = 1; tick(); start = 0;
      m = gf_f(m); got = 0; cyc = 0;
      while (got < bl && cyc < 200) begin
        out_ready = 1'($urandom_range(0, 1));
        checks++; if (out_valid !== 1'b1 || out_data !== m) begin
          errors++; $display("FAIL rb%0d_word%0d got %0d/v%0b exp %0d/v1", r, got, out_data, out_valid, m); end
        tick();
        if (out_ready) begin
          got++; exp_cnt++;
          if (got < bl) m = gf_f(m);
        end
        cyc++;
      end
      out_ready = 0;
      checks++; if (cyc >= 200) begin errors++; $display("FAIL rb%0d_timeout got %0d words exp %0d", r, got, bl); end
      checks++; if (busy !== 1'b0 || word_cnt !== exp_cnt || out_data !== m) begin
        errors++; $display("FAIL rb%0d_end got b%0b c%0d d%0d exp b0 c%0d d%0d", r, busy, word_cnt, out_data, exp_cnt, m); end
    end
  endtask

  task automatic test_fixed_point();
    logic [30:0] p;
    logic [30:0] ns;
    p = 31'd1;
    for (int k = 0; k < 4; k++) p = gf_div_x(p);
    do_seed(p);
    checks++; if (stuck !== 1'b0) begin errors++; $display("FAIL fp_preload got %0b exp 0", stuck); end
    burst_len = 16'd2; out_ready = 1; start = 1; tick(); start = 0;
    for (int k = 0; k < 2; k++) begin
      checks++; if (out_data !== p || stuck !== 1'b1) begin
        errors++; $display("FAIL fp_word%0d got %0d/s%0b exp %0d/s1", k, out_data, stuck, p); end
      tick();
    end
    out_ready = 0;
    checks++; if (busy !== 1'b0 || stuck !== 1'b1) begin
      errors++; $display("FAIL fp_idle got b%0b s%0b exp b0 s1", busy, stuck); end
    ns = 31'($urandom) | 31'd2;
    do_seed(ns);
    checks++; if (stuck !== 1'b0 || out_data !== ns) begin
      errors++; $display("FAIL fp_clear got s%0b d%0d exp s0 d%0d", stuck, out_data, ns); end
  endtask

  task automatic test_reset_mid();
    do_seed(31'd1);
    burst_len = 16'd10; out_ready = 1; start = 1; tick(); start = 0;
    for (int k = 0; k < 4; k++) tick();
    checks++; if (word_cnt !== 32'd4 || busy !== 1'b1) begin
      errors++; $display("FAIL rm_pre got c%0d b%0b exp c4 b1", word_cnt, busy); end
    rst = 1; tick(); rst = 0; out_ready = 0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || word_cnt !== 32'd0 || out_data !== 31'd1) begin
      errors++; $display("FAIL rm_post got v%0b b%0b c%0d d%0d exp v0 b0 c0 d1", out_valid, busy, word_cnt, out_data); end
    burst_len = 16'd1; out_ready = 1; start = 1; tick(); start = 0;
    checks++; if (out_valid !== 1'b1 || out_data !== 31'd16) begin
      errors++; $display("FAIL rm_restart got %0d/v%0b exp 16/v1", out_data, out_valid); end
    tick(); out_ready = 0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_burst();
    test_seed_start();
    test_backpressure();
    test_continuous();
    test_random_burst();
    test_fixed_point();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
